pack_s3_lane_sipo: RTL and testbench

Upstream feeder of the SHA3-256 absorber in the encaps datapath. Accepts one ternary coefficient per sipo_t_clk cycle and packs each 5 trits into one pack_S3 byte (c0 + 3c1 + 9c2 + 27c3 + 81c4). Assembles the bytes into 64-bit little-endian Keccak lanes and hands the lanes to the hash stage over a valid/ready handshake. Tracks the frame so the final partial lane is flagged for padding.

---
 rtl/ntru_hrss_pkg.sv | 38 +++
 rtl/pack_s3_digit_acc.sv | 45 ++++
 rtl/pack_s3_lane_sipo.sv | 117 +++++++++++
 tb/tb_pack_s3_lane_sipo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_hrss_pkg.sv
// rtl/ntru_hrss_pkg.sv - shared constants and types for the pack_S3 lane packer
package ntru_hrss_pkg;
   localparam int N                  = 701;
   localparam int N_COEF             = N - 1;
   localparam int TRITS_PER_BYTE     = 5;
   localparam int PACK_TRINARY_BYTES = N_COEF / TRITS_PER_BYTE;
   localparam int LANE_BYTES         = 8;

   localparam logic [1:0] TRIT_ZERO    = 2'd0;
   localparam logic [1:0] TRIT_ONE     = 2'd1;
   localparam logic [1:0] TRIT_TWO     = 2'd2;
   localparam logic [1:0] TRIT_ILLEGAL = 2'd3;

   localparam logic [2:0] DIGIT_LAST = 3'(TRITS_PER_BYTE - 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DONE   = 2'd2
   } sipo_state_e;

   // Base-3 place value of one trit; the illegal code contributes nothing.
   function automatic logic [8:0] trit_contrib(input logic [1:0] t, input logic [2:0] d);
      logic [8:0] w;
      case (d)
         3'd0:    w = 9'd1;
         3'd1:    w = 9'd3;
         3'd2:    w = 9'd9;
         3'd3:    w = 9'd27;
         default: w = 9'd81;
      endcase
      case (t)
         TRIT_ONE: trit_contrib = w;
         TRIT_TWO: trit_contrib = w << 1;
         default:  trit_contrib = 9'd0;
      endcase
   endfunction
endpackage

// File: rtl/pack_s3_digit_acc.sv
// rtl/pack_s3_digit_acc.sv - five-trit base-3 accumulator producing one pack_S3 byte
module pack_s3_digit_acc
   import ntru_hrss_pkg::*;
(
   input  logic       sipo_t_clk,
   input  logic       ovr_rst1,
   input  logic       clear,
   input  logic       accept,
   input  logic [1:0] trit,
   output logic [2:0] digit,
   output logic       byte_done,
   output logic [7:0] byte_next,
   output logic       err_trit
);
   logic [8:0] acc;
   logic [8:0] acc_next;

   always_comb begin
      acc_next  = acc + trit_contrib(trit, digit);
      byte_done = accept && (digit == DIGIT_LAST);
      byte_next = acc_next[7:0];
   end

   always_ff @(posedge sipo_t_clk or posedge ovr_rst1) begin
      if (ovr_rst1) begin
         digit    <= 3'd0;
         acc      <= 9'd0;
         err_trit <= 1'b0;
      end else if (clear) begin
         digit    <= 3'd0;
         acc      <= 9'd0;
         err_trit <= 1'b0;
      end else if (accept) begin
         if (digit == DIGIT_LAST) begin
            digit <= 3'd0;
            acc   <= 9'd0;
         end else begin
            digit <= digit + 3'd1;
            acc   <= acc_next;
         end
         if (trit == TRIT_ILLEGAL)
            err_trit <= 1'b1;
      end
   end
endmodule

// File: rtl/pack_s3_lane_sipo.sv
// rtl/pack_s3_lane_sipo.sv - packs trits into pack_S3 bytes and 64-bit Keccak lanes
module pack_s3_lane_sipo
   import ntru_hrss_pkg::*;
(
   input  logic        ovr_rst1,
   input  logic        sipo_t_clk,
   input  logic        frame_start,
   input  logic [1:0]  trit_in,
   input  logic        trit_valid,
   output logic        trit_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic [63:0] lane_out,
   output logic [3:0]  lane_bytes,
   output logic        lane_last,
   output logic        lane_valid,
   input  logic        lane_ready,
   output logic        frame_done,
   output logic        err_trit
);
   localparam logic [9:0] COEF_LAST = 10'(N_COEF - 1);
   localparam logic [2:0] SLOT_LAST = 3'(LANE_BYTES - 1);

   sipo_state_e state;
   logic [2:0]  byte_cnt;
   logic [9:0]  coef_cnt;
   logic [63:0] asm_q;
   logic [63:0] lane_fill;
   logic [2:0]  digit;
   logic        byte_done;
   logic [7:0]  byte_next;
   logic        accept;
   logic        frame_last;
   logic        lane_close;

   // The byte that closes a lane (full or final partial) needs an empty holding register.
   always_comb begin
      frame_last = (coef_cnt == COEF_LAST);
      lane_close = (byte_cnt == SLOT_LAST) || frame_last;
      trit_ready = (state == ST_ACTIVE) && !(lane_valid && lane_close && (digit == DIGIT_LAST));
      accept     = trit_valid && trit_ready;
      lane_fill  = asm_q | (64'(byte_next) << {byte_cnt, 3'b000});
   end

   pack_s3_digit_acc u_digit_acc (
      .sipo_t_clk (sipo_t_clk),
      .ovr_rst1   (ovr_rst1),
      .clear      (frame_start),
      .accept     (accept),
      .trit       (trit_in),
      .digit      (digit),
      .byte_done  (byte_done),
      .byte_next  (byte_next),
      .err_trit   (err_trit)
   );

   always_ff @(posedge sipo_t_clk or posedge ovr_rst1) begin
      if (ovr_rst1) begin
         state      <= ST_ACTIVE;
         byte_cnt   <= 3'd0;
         coef_cnt   <= 10'd0;
         asm_q      <= 64'd0;
         byte_out   <= 8'd0;
         byte_valid <= 1'b0;
         lane_out   <= 64'd0;
         lane_bytes <= 4'd0;
         lane_last  <= 1'b0;
         lane_valid <= 1'b0;
         frame_done <= 1'b0;
      end else if (frame_start) begin
         state      <= ST_ACTIVE;
         byte_cnt   <= 3'd0;
         coef_cnt   <= 10'd0;
         asm_q      <= 64'd0;
         byte_out   <= 8'd0;
         byte_valid <= 1'b0;
         lane_out   <= 64'd0;
         lane_bytes <= 4'd0;
         lane_last  <= 1'b0;
         lane_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         byte_valid <= byte_done;
         if (accept)
            coef_cnt <= coef_cnt + 10'd1;
         if (byte_done) begin
            byte_out <= byte_next;
            if (lane_close) begin
               asm_q    <= 64'd0;
               byte_cnt <= 3'd0;
            end else begin
               asm_q    <= lane_fill;
               byte_cnt <= byte_cnt + 3'd1;
            end
         end
         if (byte_done && lane_close) begin
            lane_out   <= lane_fill;
            lane_bytes <= 4'(byte_cnt) + 4'd1;
            lane_last  <= frame_last;
            lane_valid <= 1'b1;
         end else if (lane_valid && lane_ready) begin
            lane_valid <= 1'b0;
         end
         case (state)
            ST_ACTIVE: if (byte_done && frame_last) state <= ST_FLUSH;
            ST_FLUSH: begin
               if (lane_valid && lane_ready) begin
                  state      <= ST_DONE;
                  frame_done <= 1'b1;
               end
            end
            ST_DONE:   state <= ST_DONE;
            default:   state <= ST_ACTIVE;
         endcase
      end
   end
endmodule

// File: tb/tb_pack_s3_lane_sipo.sv
// tb/tb_pack_s3_lane_sipo.sv - self-checking bench for pack_s3_lane_sipo
module tb_pack_s3_lane_sipo;
   logic        ovr_rst1, sipo_t_clk, frame_start;
   logic [1:0]  trit_in;
   logic        trit_valid, trit_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic [63:0] lane_out;
   logic [3:0]  lane_bytes;
   logic        lane_last, lane_valid, lane_ready, frame_done, err_trit;

   pack_s3_lane_sipo dut (
      .ovr_rst1(ovr_rst1), .sipo_t_clk(sipo_t_clk), .frame_start(frame_start),
      .trit_in(trit_in), .trit_valid(trit_valid), .trit_ready(trit_ready),
      .byte_out(byte_out), .byte_valid(byte_valid), .lane_out(lane_out),
      .lane_bytes(lane_bytes), .lane_last(lane_last), .lane_valid(lane_valid),
      .lane_ready(lane_ready), .frame_done(frame_done), .err_trit(err_trit)
   );

   initial sipo_t_clk = 1'b0;
   always #5 sipo_t_clk = ~sipo_t_clk;

   int n_pass = 0;
   int n_total = 0;
   bit rnd = 1'b0;
   int acc_cnt = 0;

   logic [1:0]  sent_q[$];
   logic [63:0] got_lane[$];
   logic [3:0]  got_nb[$];
   logic        got_last[$];
   logic [7:0]  got_byte[$];
   logic [63:0] exp_lane[$];
   logic [3:0]  exp_nb[$];
   logic        exp_last[$];
   logic [7:0]  exp_byte[$];

   // Inputs change just after posedge, so negedge sees exactly what the next edge will act on.
   always @(negedge sipo_t_clk) begin
      if (lane_valid && lane_ready) begin
         got_lane.push_back(lane_out);
         got_nb.push_back(lane_bytes);
         got_last.push_back(lane_last);
      end
      if (byte_valid) got_byte.push_back(byte_out);
      if (trit_valid && trit_ready) acc_cnt = acc_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_model();
      sent_q.delete(); got_lane.delete(); got_nb.delete(); got_last.delete(); got_byte.delete();
      acc_cnt = 0;
   endtask

   task automatic fstart();
      trit_valid = 1'b0;
      frame_start = 1'b1;
      @(posedge sipo_t_clk); #1;
      frame_start = 1'b0;
      clear_model();
   endtask

   task automatic send(input logic [1:0] t);
      bit ok;
      int w;
      if (rnd && $urandom_range(0, 3) == 0) begin
         trit_valid = 1'b0;
         @(posedge sipo_t_clk); #1;
         lane_ready = 1'($urandom_range(0, 1));
      end
      trit_valid = 1'b1;
      trit_in = t;
      w = 0;
      forever begin
         @(negedge sipo_t_clk);
         ok = trit_ready;
         @(posedge sipo_t_clk); #1;
         if (rnd) lane_ready = 1'($urandom_range(0, 1));
         if (ok) begin
            sent_q.push_back(t);
            break;
         end
         w = w + 1;
         if (w > 200) begin
            n_total = n_total + 1;
            $error("FAIL accept_timeout: observed no accept after %0d cycles expected accept", w);
            break;
         end
      end
   endtask

   task automatic wait_done();
      for (int k = 0; k < 400 && !frame_done; k++) begin
         @(posedge sipo_t_clk); #1;
         if (rnd) lane_ready = 1'($urandom_range(0, 1));
      end
   endtask

   function automatic logic [7:0] pack5(input int base);
      int v, pw;
      v = 0; pw = 1;
      for (int i = 0; i < 5; i++) begin
         if (sent_q[base + i] != 2'd3) v = v + int'(sent_q[base + i]) * pw;
         pw = pw * 3;
      end
      return 8'(v);
   endfunction

   // Expected bytes/lanes straight from the list of accepted trits.
   task automatic build_model(input bit whole_frame);
      int nb, n;
      logic [63:0] d;
      exp_byte.delete(); exp_lane.delete(); exp_nb.delete(); exp_last.delete();
      nb = sent_q.size() / 5;
      for (int b = 0; b < nb; b++) exp_byte.push_back(pack5(5 * b));
      for (int s = 0; s < nb; s += 8) begin
         n = (nb - s < 8) ? nb - s : 8;
         if (n == 8 || whole_frame) begin
            d = 64'd0;
            for (int j = 0; j < n; j++) d[8*j +: 8] = exp_byte[s + j];
            exp_lane.push_back(d);
            exp_nb.push_back(4'(n));
            exp_last.push_back(whole_frame && (s + n == nb));
         end
      end
   endtask

   task automatic compare_all(input string tag, input bit whole_frame);
      build_model(whole_frame);
      check({tag, " trits"}, 64'(acc_cnt), 64'(sent_q.size()));
      check({tag, " nbytes"}, 64'(got_byte.size()), 64'(exp_byte.size()));
      check({tag, " nlanes"}, 64'(got_lane.size()), 64'(exp_lane.size()));
      for (int i = 0; i < exp_byte.size() && i < got_byte.size(); i++)
         check($sformatf("%s byte%0d", tag, i), 64'(got_byte[i]), 64'(exp_byte[i]));
      for (int i = 0; i < exp_lane.size() && i < got_lane.size(); i++) begin
         check($sformatf("%s lane%0d", tag, i), got_lane[i], exp_lane[i]);
         check($sformatf("%s nb%0d", tag, i), 64'(got_nb[i]), 64'(exp_nb[i]));
         check($sformatf("%s last%0d", tag, i), 64'(got_last[i]), 64'(exp_last[i]));
      end
   endtask

   initial begin
      ovr_rst1 = 1'b1; frame_start = 1'b0; trit_in = 2'd0; trit_valid = 1'b0; lane_ready = 1'b0;
      repeat (3) @(posedge sipo_t_clk);
      #1 ovr_rst1 = 1'b0;
      check("rst trit_ready", 64'(trit_ready), 64'd1);
      check("rst lane_valid", 64'(lane_valid), 64'd0);
      check("rst byte_valid", 64'(byte_valid), 64'd0);
      check("rst frame_done", 64'(frame_done), 64'd0);
      check("rst lane_out", lane_out, 64'd0);
      check("rst byte_out", 64'(byte_out), 64'd0);
      clear_model();

      // Directed byte 1,2,0,1,2
      lane_ready = 1'b1;
      send(2'd1); send(2'd2); send(2'd0); send(2'd1); send(2'd2);
      trit_valid = 1'b0;
      check("t1 byte_valid", 64'(byte_valid), 64'd1);
      check("t1 byte_out", 64'(byte_out), 64'hC4);
      @(posedge sipo_t_clk); #1;
      check("t1 byte_valid pulse", 64'(byte_valid), 64'd0);

      // 40 trits of 2 fill one full lane
      fstart();
      for (int i = 0; i < 39; i++) send(2'd2);
      check("t2 lane_valid early", 64'(lane_valid), 64'd0);
      send(2'd2);
      trit_valid = 1'b0;
      check("t2 lane_valid", 64'(lane_valid), 64'd1);
      check("t2 lane_out", lane_out, 64'hF2F2F2F2F2F2F2F2);
      check("t2 lane_bytes", 64'(lane_bytes), 64'd8);
      check("t2 lane_last", 64'(lane_last), 64'd0);
      repeat (3) @(posedge sipo_t_clk); #1;
      compare_all("t2", 1'b0);

      // Backpressure: holding register full, second lane about to close
      fstart();
      lane_ready = 1'b0;
      for (int i = 0; i < 79; i++) begin
         send(2'($urandom_range(0, 2)));
         if (i == 77) check("t3 ready before stall", 64'(trit_ready), 64'd1);
      end
      check("t3 ready stalled", 64'(trit_ready), 64'd0);
      trit_in = 2'($urandom_range(0, 2));
      repeat (4) @(posedge sipo_t_clk); #1;
      check("t3 no accept while stalled", 64'(acc_cnt), 64'd79);
      lane_ready = 1'b1;
      send(trit_in);
      trit_valid = 1'b0;
      repeat (4) @(posedge sipo_t_clk); #1;
      compare_all("t3", 1'b0);

      // Full frame of ones
      fstart();
      for (int i = 0; i < 700; i++) send(2'd1);
      trit_valid = 1'b0;
      wait_done();
      check("t4 frame_done", 64'(frame_done), 64'd1);
      check("t4 trit_ready", 64'(trit_ready), 64'd0);
      check("t4 lane_valid", 64'(lane_valid), 64'd0);
      check("t4 lanes", 64'(got_lane.size()), 64'd18);
      if (got_lane.size() == 18) begin
         check("t4 lane0", got_lane[0], 64'h7979797979797979);
         check("t4 lane16", got_lane[16], 64'h7979797979797979);
         check("t4 lane17", got_lane[17], 64'h0000000079797979);
         check("t4 lane17 nb", 64'(got_nb[17]), 64'd4);
         check("t4 lane17 last", 64'(got_last[17]), 64'd1);
      end
      compare_all("t4", 1'b1);

      // Random frame with random gaps and random backpressure
      fstart();
      rnd = 1'b1;
      for (int i = 0; i < 700; i++) send(2'($urandom_range(0, 2)));
      trit_valid = 1'b0;
      wait_done();
      rnd = 1'b0;
      lane_ready = 1'b1;
      check("t4r frame_done", 64'(frame_done), 64'd1);
      check("t4r trit_ready", 64'(trit_ready), 64'd0);
      compare_all("t4r", 1'b1);

      // Asynchronous reset in the middle of a byte
      fstart();
      for (int i = 0; i < 13; i++) send(2'($urandom_range(0, 2)));
      trit_valid = 1'b0;
      ovr_rst1 = 1'b1;
      #2;
      check("t5 rst trit_ready", 64'(trit_ready), 64'd1);
      check("t5 rst byte_out", 64'(byte_out), 64'd0);
      check("t5 rst lane_out", lane_out, 64'd0);
      check("t5 rst lane_valid", 64'(lane_valid), 64'd0);
      @(posedge sipo_t_clk); #1;
      ovr_rst1 = 1'b0;
      clear_model();
      for (int i = 0; i < 5; i++) send(2'd2);
      trit_valid = 1'b0;
      check("t5 byte_out", 64'(byte_out), 64'hF2);
      check("t5 byte_valid", 64'(byte_valid), 64'd1);

      // Illegal trit
      fstart();
      check("t6 err clear", 64'(err_trit), 64'd0);
      send(2'd3); send(2'd1); send(2'd1); send(2'd1); send(2'd1);
      trit_valid = 1'b0;
      check("t6 byte_out", 64'(byte_out), 64'h78);
      check("t6 err_trit", 64'(err_trit), 64'd1);
      for (int i = 0; i < 5; i++) send(2'd0);
      trit_valid = 1'b0;
      check("t6 err sticky", 64'(err_trit), 64'd1);
      fstart();
      check("t6 err cleared", 64'(err_trit), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
